// File: rtl/interval_counter_if.sv
// Control and status bundle for the programmable interval counter.
// master drives the controls; slave (the counter) returns count and flags.
interface interval_counter_if #(
    parameter int DATA_WIDTH     = 10,
    parameter int PRESCALE_WIDTH = 8
);
    logic                      en;
    logic                      clr;
    logic                      load;
    logic [DATA_WIDTH-1:0]     load_val;
    logic [DATA_WIDTH-1:0]     max_val;
    logic                      dir;
    logic                      mode;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [DATA_WIDTH-1:0]     out;
    logic                      tc;
    logic                      done;

    modport master (
        output en, clr, load, load_val, max_val, dir, mode, prescale,
        input  out, tc, done
    );

    modport slave (
        input  en, clr, load, load_val, max_val, dir, mode, prescale,
        output out, tc, done
    );
endinterface

// File: rtl/interval_counter.sv
// Programmable up/down interval counter with prescaler, periodic or
// one-shot mode and a one-cycle terminal-count pulse.
module interval_counter #(
    parameter int DATA_WIDTH     = 10,
    parameter int PRESCALE_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    interval_counter_if.slave bus
);
    typedef enum logic {RUN, DONE} state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     cnt;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic                      tc_q;
    logic                      done_q;
    logic                      tick;
    logic                      term;

    assign tick = (pre_cnt == bus.prescale);
    assign term = bus.dir ? (cnt >= bus.max_val) : (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            cnt     <= '0;
            pre_cnt <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.clr) begin
            state   <= RUN;
            cnt     <= '0;
            pre_cnt <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.load) begin
            state   <= RUN;
            cnt     <= bus.load_val;
            pre_cnt <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (state == RUN && bus.en) begin
            if (tick) begin
                pre_cnt <= '0;
                if (term) begin
                    tc_q <= 1'b1;
                    if (bus.mode) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= bus.dir ? '0 : bus.max_val;
                    end
                end else begin
                    tc_q <= 1'b0;
                    // Terminal checks above keep these from wrapping.
                    cnt  <= bus.dir ? cnt + DATA_WIDTH'(1)
                                    : cnt - DATA_WIDTH'(1);
                end
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
                tc_q    <= 1'b0;
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.out  = cnt;
    assign bus.tc   = tc_q;
    assign bus.done = done_q;
endmodule

// File: doc/interval_counter.md
# interval_counter

- Programmable interval counter: the parametrised successor to the free-running wrap counter.
- Adds clock-enable, a prescaler, run-time modulo, up/down direction, synchronous clear/load, periodic or one-shot mode, and a one-cycle terminal-count pulse.
- Sits between the system clock and the temperature-sensor sampling logic, generating sample intervals and timeouts without per-interval RTL changes.

## Interface
- DATA_WIDTH, 10, width of count value, max_val and load_val
- PRESCALE_WIDTH, 8, width of prescale input and internal prescaler

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable; low freezes prescaler and count
- clr  input  1  synchronous clear
- load  input  1  synchronous load of load_val
- load_val  input  DATA_WIDTH  value loaded into out on load
- max_val  input  DATA_WIDTH  run-time modulo (terminal value when counting up, reload value when counting down)
- dir  input  1  1 = count up, 0 = count down
- mode  input  1  0 = periodic, 1 = one-shot
- prescale  input  PRESCALE_WIDTH  a count tick occurs every prescale+1 enabled cycles
- out  output  DATA_WIDTH  current count
- tc  output  1  one-cycle terminal-count pulse
- done  output  1  high while a one-shot has expired

## Operation
- Reset (rst low, asynchronous): out=0, internal prescaler pre_cnt=0, tc=0, done=0, state=RUN.
- States:
  - RUN: counting.
  - DONE: one-shot expired; done=1; out and pre_cnt hold; en ignored.
- Priority per clock edge: clr > load > tick.
  - clr: out=0, pre_cnt=0, tc=0, state=RUN. Ignores en.
  - load: out=load_val, pre_cnt=0, tc=0, state=RUN. Ignores en.
- Prescaler, active only in RUN with en=1:
  - If pre_cnt==prescale: tick this cycle, pre_cnt<=0.
  - Otherwise pre_cnt<=pre_cnt+1.
  - prescale=0 gives a tick on every enabled cycle.
  - A change of prescale takes effect at the comparison. If pre_cnt>prescale, pre_cnt counts up and wraps through its full width, modulo 2^PRESCALE_WIDTH.
- Terminal condition, evaluated on tick:
  - Up: out>=max_val. The >= covers out above max_val after a load or a max_val change.
  - Down: out==0.
- On a tick without terminal: out<=out+1 (up) or out-1 (down), tc<=0.
- On a tick with terminal, tc<=1 and:
  - Periodic: out<=0 (up) or out<=max_val (down); stay RUN.
  - One-shot: out holds, state<=DONE, done<=1.
- tc is 0 on every edge with no terminal tick. tc is never high on two consecutive cycles unless terminal ticks occur on consecutive cycles (prescale=0 with max_val=0 counting up, or max_val=0 counting down).
- max_val=0: every tick is terminal and out stays 0 in either direction.
- dir, mode and max_val are sampled at each tick and need no synchronisation.
- Changing mode from 1 to 0 while in DONE does not restart counting; only clr or load leave DONE.
- Down count from a loaded value above max_val decrements normally to 0, then reloads max_val.
- Arithmetic is modulo 2^DATA_WIDTH. With the rules above, no over- or underflow is reachable in up/down counting.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Latency:
  - clr or load to out: 1 cycle.
  - Tick to out update: the same edge.
  - tc is high for the cycle following the terminal edge, coincident with the wrapped or held out value.
- Interval in periodic up mode with en held high: terminal ticks every (max_val+1)*(prescale+1) cycles.
- en deassertion takes effect on the same edge. Prescaler phase is preserved across en gaps.
- Reset mid-count aborts immediately and asynchronously. The first tick after rst rises occurs prescale+1 enabled cycles later.

## Test plan
- Reset/basic: rst low mid-count, then en=1, dir=1, mode=0, prescale=0, max_val=3:
  - While rst is low: out=0, tc=0, done=0.
  - After release: out runs 1,2,3,0,1; tc high exactly in the cycles where out=0 after wrap.
- Prescaler/enable: prescale=2, max_val=5, en toggled low for 4 cycles mid-count:
  - out advances every 3rd enabled cycle.
  - out and phase are frozen while en=0.
  - Period between tc pulses is 18 enabled cycles.
- Down/one-shot: load_val=4, load pulse, dir=0, mode=1, prescale=0:
  - out runs 4,3,2,1,0, then holds 0.
  - tc=1 for one cycle; done=1 persists for 10 cycles with en=1.
  - A following load of 7 clears done; out=7 one cycle later.
- Priority/out-of-range: clr, load (load_val=9) and a terminal tick on the same edge → out=0. Then load_val=9 with max_val=5 counting up → next tick out=0 with tc=1.
- Edge values:
  - max_val=0, prescale=0 → out stays 0, tc high every cycle.
  - max_val=2^DATA_WIDTH-1 up → out reaches 1023, then 0 with tc.
  - prescale=255 → tick every 256 cycles.
